// File: rtl/burst_memory_responder_if.sv
// Bus bundle between a burst master and burst_memory_responder.
// The master modport drives requests and write data; the slave modport returns read data and status.
interface burst_memory_responder_if;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busyOut;
    logic        busErrorOut;

    modport master (
        output beginTransactionIn, addressDataIn, readNotWriteIn, byteEnablesIn,
               burstSizeIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
    );

    modport slave (
        input  beginTransactionIn, addressDataIn, readNotWriteIn, byteEnablesIn,
               burstSizeIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
    );
endinterface

// File: rtl/burst_memory_responder.sv
// Burst memory responder: a 2^ADDR_BITS-word window at BASE_ADDRESS with byte-lane burst writes and pipelined burst reads.
// Optional macro RESPONDER_STALL_EN inserts a one-cycle busyOut stall after every 4th accepted write beat.
module burst_memory_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
    parameter int unsigned ADDR_BITS    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    burst_memory_responder_if.slave  bus
);
    localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
    localparam int unsigned SUM_BITS = ADDR_BITS + 9;
    localparam logic [SUM_BITS-1:0] LAST_INDEX = {9'b0, {ADDR_BITS{1'b1}}};

    typedef enum logic [2:0] {IDLE, WRITE, READ, RDEND, ERROR} state_t;

    state_t state;
    state_t state_next;

    logic [31:0]          mem [DEPTH];
    logic [31:0]          rd_word;
    logic [ADDR_BITS-1:0] ptr;
    logic [8:0]           beats_left;
    logic [3:0]           byte_en;
    logic                 rd_valid;
    logic                 stall;

    logic [ADDR_BITS-1:0] begin_index;
    logic [SUM_BITS-1:0]  end_index;
    logic                 selected;
    logic                 misaligned;
    logic                 overrun;
    logic                 start;

    logic                 wr_accept;
    logic                 rd_issue;
    logic                 rd_done;
    logic                 err_pulse;

    // Request decode, only meaningful in the begin cycle
    assign begin_index = bus.addressDataIn[ADDR_BITS+1:2];
    assign selected    = bus.addressDataIn[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2];
    assign misaligned  = |bus.addressDataIn[1:0];
    assign end_index   = SUM_BITS'(begin_index) + SUM_BITS'(bus.burstSizeIn);
    assign overrun     = end_index > LAST_INDEX;
    assign start       = (state == IDLE) && bus.beginTransactionIn && selected;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (misaligned || overrun) begin
                        state_next = ERROR;
                    end else if (bus.readNotWriteIn) begin
                        state_next = READ;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.endTransactionIn || (wr_accept && beats_left == 9'd1)) begin
                    state_next = IDLE;
                end
            end
            READ: begin
                if (bus.endTransactionIn) begin
                    state_next = IDLE;
                end else if (beats_left == 9'd0) begin
                    state_next = RDEND;
                end
            end
            RDEND:   state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        wr_accept = 1'b0;
        rd_issue  = 1'b0;
        rd_done   = 1'b0;
        err_pulse = 1'b0;
        unique case (state)
            WRITE:   wr_accept = bus.dataValidIn && !stall && !bus.endTransactionIn;
            READ:    rd_issue  = !bus.endTransactionIn && (beats_left != 9'd0);
            RDEND:   rd_done   = 1'b1;
            ERROR:   err_pulse = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            beats_left <= '0;
            byte_en    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_issue;
            if (start) begin
                ptr        <= begin_index;
                beats_left <= {1'b0, bus.burstSizeIn} + 9'd1;
                byte_en    <= bus.byteEnablesIn;
            end else if (wr_accept || rd_issue) begin
                ptr        <= ptr + ADDR_BITS'(1);
                beats_left <= beats_left - 9'd1;
            end
        end
    end

    // NOTE: the storage array has no reset so contents survive reset and the array maps onto RAM.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[ptr][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
                end
            end
        end
        rd_word <= mem[ptr];
    end

`ifdef RESPONDER_STALL_EN
    logic [1:0] beat_phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall      <= 1'b0;
            beat_phase <= '0;
        end else begin
            stall <= wr_accept && (beat_phase == 2'd3);
            if (start) begin
                beat_phase <= '0;
            end else if (wr_accept) begin
                beat_phase <= beat_phase + 2'd1;
            end
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Read data is masked so the bus is zero whenever no beat is presented
    assign bus.addressDataOut    = rd_valid ? rd_word : 32'h0;
    assign bus.dataValidOut      = rd_valid;
    assign bus.endTransactionOut = rd_done;
    assign bus.busErrorOut       = err_pulse;
    assign bus.busyOut           = stall;
endmodule

// File: tb/tb_burst_memory_responder.sv
// Scoreboard bench for burst_memory_responder: directed cases plus randomized bursts against an array model.
// Define RESPONDER_STALL_EN for both bench and design to exercise the write-stall variant.
module tb_burst_memory_responder;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          WORDS = 256;
`ifdef RESPONDER_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    typedef enum int {EV_DATA, EV_END, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    exp_t        sbq[$];
    logic [31:0] model [WORDS];
    logic [31:0] wq[$];

    burst_memory_responder_if bus();

    burst_memory_responder #(.BASE_ADDRESS(BASE), .ADDR_BITS(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.dataValidOut), 32'h0);
        check({tag, "_data"},  bus.addressDataOut,   32'h0);
        check({tag, "_end"},   32'(bus.endTransactionOut), 32'h0);
        check({tag, "_busy"},  32'(bus.busyOut),      32'h0);
        check({tag, "_error"}, 32'(bus.busErrorOut),  32'h0);
    endtask

    // Monitor: every presented response must match the oldest expectation, in kind, cycle and data
    task automatic expect_event(input ev_kind_t kind, input logic [31:0] data);
        exp_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_response at cycle %0d: got kind %0d data %h, expected nothing", cyc, kind, data);
            return;
        end
        e = sbq.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_cycle", cyc, e.cyc);
        if (kind == EV_DATA) check("read_data", data, e.data);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.dataValidOut) expect_event(EV_DATA, bus.addressDataOut);
            else check("data_zero_when_not_valid", bus.addressDataOut, 32'h0);
            if (bus.endTransactionOut) expect_event(EV_END, 32'h0);
            if (bus.busErrorOut) expect_event(EV_ERR, 32'h0);
`ifndef RESPONDER_STALL_EN
            check("busy_constant_zero", 32'(bus.busyOut), 32'h0);
`endif
        end
    end

    // Reference rules, stated directly as address arithmetic
    function automatic bit in_window(input logic [31:0] a);
        return (a / 1024) == (BASE / 1024);
    endfunction

    function automatic bit bad_request(input logic [31:0] a, input int burst);
        return (a % 4 != 0) || (int'((a % 1024) / 4) + burst > WORDS - 1);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_begin(input logic [31:0] addr, input bit rnw, input logic [3:0] be, input int burst);
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = addr;
        bus.readNotWriteIn     = rnw;
        bus.byteEnablesIn      = be;
        bus.burstSizeIn        = 8'(burst);
    endtask

    // stop_after >= 0 ends the burst after that many accepted beats, by endTransactionIn or by reset
    task automatic do_write(input logic [31:0] addr, input int burst, input logic [3:0] be,
                            input int stop_after, input bit stop_by_reset);
        int          t, idx, n, accepted, tries;
        bit          exp_busy, b;
        logic [31:0] d;
        issue_begin(addr, 1'b0, be, burst);
        t = cyc;
        tick();
        bus.beginTransactionIn = 1'b0;
        if (!in_window(addr) || bad_request(addr, burst)) begin
            if (in_window(addr)) sbq.push_back('{EV_ERR, t + 1, 32'h0});
            bus.dataValidIn = 1'b1;
            bus.addressDataIn = $urandom;
            tick();
            bus.addressDataIn = $urandom;
            tick();
            bus.dataValidIn = 1'b0;
            tick();
            wq.delete();
            return;
        end
        idx = int'((addr % 1024) / 4);
        n = (stop_after >= 0) ? stop_after : burst + 1;
        accepted = 0;
        exp_busy = 1'b0;
        while (accepted < n) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.dataValidIn = 1'b0;
                @(negedge clock);
                check("busy_in_gap", 32'(bus.busyOut), 32'(exp_busy));
                exp_busy = 1'b0;
                tick();
            end
            d = (wq.size() != 0) ? wq.pop_front() : $urandom;
            bus.dataValidIn = 1'b1;
            bus.addressDataIn = d;
            tries = 0;
            do begin
                @(negedge clock);
                check("busy_before_beat", 32'(bus.busyOut), 32'(exp_busy));
                b = bus.busyOut;
                exp_busy = 1'b0;
                tries++;
                tick();
            end while (b && tries < 8);
            for (int l = 0; l < 4; l++) begin
                if (be[l]) model[idx + accepted][8*l +: 8] = d[8*l +: 8];
            end
            accepted++;
            exp_busy = STALL && (accepted % 4 == 0);
        end
        bus.dataValidIn = 1'b0;
        if (stop_after >= 0 && stop_by_reset) begin
            reset = 1'b1;
            tick();
            @(negedge clock);
            check_all_zero("reset_mid_write");
            tick();
            reset = 1'b0;
            tick();
        end else if (stop_after >= 0) begin
            bus.endTransactionIn = 1'b1;
            @(negedge clock);
            check("busy_at_abort", 32'(bus.busyOut), 32'(exp_busy));
            tick();
            bus.endTransactionIn = 1'b0;
        end else begin
            @(negedge clock);
            check("busy_after_last_beat", 32'(bus.busyOut), 32'(exp_busy));
            tick();
        end
        wq.delete();
    endtask

    // abort_beats >= 1 raises endTransactionIn in the cycle that presents that beat
    task automatic do_read(input logic [31:0] addr, input int burst, input int abort_beats);
        int t, idx;
        issue_begin(addr, 1'b1, 4'($urandom), burst);
        t = cyc;
        tick();
        bus.beginTransactionIn = 1'b0;
        bus.dataValidIn = 1'($urandom);
        bus.addressDataIn = $urandom;
        if (!in_window(addr)) begin
            repeat (burst + 4) tick();
        end else if (bad_request(addr, burst)) begin
            sbq.push_back('{EV_ERR, t + 1, 32'h0});
            repeat (3) tick();
        end else begin
            idx = int'((addr % 1024) / 4);
            if (abort_beats < 0) begin
                for (int i = 0; i <= burst; i++) sbq.push_back('{EV_DATA, t + 2 + i, model[idx + i]});
                sbq.push_back('{EV_END, t + 3 + burst, 32'h0});
                repeat (burst + 4) tick();
            end else begin
                for (int i = 0; i < abort_beats; i++) sbq.push_back('{EV_DATA, t + 2 + i, model[idx + i]});
                repeat (abort_beats) tick();
                bus.endTransactionIn = 1'b1;
                tick();
                bus.endTransactionIn = 1'b0;
                repeat (3) tick();
            end
        end
        bus.dataValidIn = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          burst, r, stop, t;
        bus.beginTransactionIn = 1'b0;
        bus.addressDataIn      = 32'h0;
        bus.readNotWriteIn     = 1'b0;
        bus.byteEnablesIn      = 4'h0;
        bus.burstSizeIn        = 8'h0;
        bus.dataValidIn        = 1'b0;
        bus.endTransactionIn   = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        mon_en = 1'b1;
        @(negedge clock);
        check_all_zero("reset_state");
        tick();
        reset = 1'b0;
        tick();

        // Give every word a known value
        do_write(BASE, 255, 4'hF, -1, 1'b0);

        // Four-beat write then read back with exact beat timing
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(BASE + 32'h10, 3, 4'hF, -1, 1'b0);
        do_read(BASE + 32'h10, 3, -1);

        // Byte-lane merge
        wq = '{32'h1122_3344};
        do_write(BASE, 0, 4'hF, -1, 1'b0);
        wq = '{32'hAABB_CCDD};
        do_write(BASE, 0, 4'b0101, -1, 1'b0);
        do_read(BASE, 0, -1);

        // Misaligned and overrunning requests
        do_write(BASE + 32'h2, 1, 4'hF, -1, 1'b0);
        do_read(BASE + 32'h3FC, 1, -1);
        do_write(BASE + 32'h3FC, 1, 4'hF, -1, 1'b0);
        do_read(BASE, 1, -1);
        do_read(BASE + 32'h3F8, 1, -1);
        do_read(BASE + 32'h3FC, 0, -1);

        // Unselected requests are invisible; a valid one follows
        do_read(32'h5000_0000, 3, -1);
        do_write(32'h5000_0000, 1, 4'hF, -1, 1'b0);
        do_read(BASE, 0, -1);
        do_write(BASE + 32'h100, 1, 4'hF, -1, 1'b0);
        do_read(BASE + 32'h100, 1, -1);

        // Read abort, then reset in the middle of a write burst
        do_read(BASE + 32'h20, 7, 3);
        do_write(BASE + 32'h40, 7, 4'hF, 3, 1'b1);
        do_read(BASE + 32'h40, 7, -1);
        do_read(BASE + 32'h20, 7, -1);

        // Reset while read beats are on the bus
        issue_begin(BASE, 1'b1, 4'hF, 7);
        t = cyc;
        tick();
        bus.beginTransactionIn = 1'b0;
        sbq.push_back('{EV_DATA, t + 2, model[0]});
        sbq.push_back('{EV_DATA, t + 3, model[1]});
        tick();
        tick();
        reset = 1'b1;
        tick();
        @(negedge clock);
        check_all_zero("reset_mid_read");
        tick();
        reset = 1'b0;
        tick();

        // Write aborted by the master, and an 8-beat burst that crosses two stall points
        do_write(BASE + 32'hC0, 5, 4'hF, 2, 1'b0);
        do_read(BASE + 32'hC0, 5, -1);
        do_write(BASE + 32'h80, 7, 4'hF, -1, 1'b0);
        do_read(BASE + 32'h80, 7, -1);

        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 99));
            burst = int'($urandom_range(0, 15));
            if (r < 5) a = 32'h5000_0000 | ($urandom & 32'h3FC);
            else if (r < 10) a = BASE | ($urandom & 32'h3FC) | 32'($urandom_range(1, 3));
            else a = BASE | ($urandom & 32'h3FC);
            stop = -1;
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 4) == 0 && in_window(a) && !bad_request(a, burst) && burst > 0)
                    stop = int'($urandom_range(1, burst));
                do_read(a, burst, stop);
            end else begin
                if ($urandom_range(0, 4) == 0 && in_window(a) && !bad_request(a, burst))
                    stop = int'($urandom_range(0, burst));
                do_write(a, burst, 4'($urandom), stop, 1'b0);
            end
        end

        repeat (4) tick();
        check("scoreboard_drained", sbq.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/burst_memory_responder.md
BURST_MEMORY_RESPONDER -- requirements
Module: burst_memory_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDRESS, default 32'h4000_0000: word-aligned base of the responder window.
REQ-002 The block SHALL have parameter ADDR_BITS, default 8: window depth of 2^ADDR_BITS 32-bit words.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port beginTransactionIn, input, 1 bit: start of transaction; address on addressDataIn.
REQ-006 The block SHALL have port addressDataIn, input, 32 bits: address in the begin cycle, write data afterwards.
REQ-007 The block SHALL have port readNotWriteIn, input, 1 bit: 1 = read, 0 = write; sampled with begin.
REQ-008 The block SHALL have port byteEnablesIn, input, 4 bits: write byte lanes; sampled with begin.
REQ-009 The block SHALL have port burstSizeIn, input, 8 bits: beats minus one; sampled with begin.
REQ-010 The block SHALL have port dataValidIn, input, 1 bit: write data beat present.
REQ-011 The block SHALL have port endTransactionIn, input, 1 bit: master ends or aborts the transaction.
REQ-012 The block SHALL have port addressDataOut, output, 32 bits: read data; 0 whenever dataValidOut = 0.
REQ-013 The block SHALL have port dataValidOut, output, 1 bit: read data beat present.
REQ-014 The block SHALL have port endTransactionOut, output, 1 bit: read burst complete.
REQ-015 The block SHALL have port busyOut, output, 1 bit: write beat not accepted this cycle.
REQ-016 The block SHALL have port busErrorOut, output, 1 bit: one-cycle error response.

Function
REQ-017 The FSM SHALL have states IDLE, WRITE, READ, RDEND and ERROR.
REQ-018 In IDLE with beginTransactionIn=1, the block SHALL latch the address, readNotWriteIn, byteEnablesIn and burstSizeIn.
REQ-019 A transaction SHALL be selected when addressDataIn[31:ADDR_BITS+2] equals BASE_ADDRESS[31:ADDR_BITS+2].
REQ-020 An unselected transaction SHALL be ignored: the FSM stays in IDLE and all outputs stay 0.
REQ-021 A selected transaction SHALL go to ERROR if addr[1:0]!=0 or word index + burstSize > 2^ADDR_BITS-1; otherwise it SHALL go to WRITE or READ.
REQ-022 ERROR SHALL drive busErrorOut=1 for exactly one cycle, then return to IDLE; memory SHALL NOT be modified.
REQ-023 In WRITE, each cycle with dataValidIn=1 and busyOut=0 SHALL write one word at the word pointer, only on lanes whose byte enable is 1, then increment the pointer.
REQ-024 WRITE SHALL return to IDLE after burstSize+1 accepted beats, or immediately on endTransactionIn; beats already written SHALL be kept.
REQ-025 A read SHALL have begin at cycle T, READ at T+1 (synchronous memory read) and the first dataValidOut at T+2.
REQ-026 A read SHALL then deliver one beat per cycle, burstSize+1 beats in total, with byte enables ignored.
REQ-027 endTransactionOut SHALL be 1 for exactly one cycle (RDEND), in the cycle after the last data beat, then the FSM SHALL return to IDLE.
REQ-028 endTransactionIn during READ SHALL abort the read: dataValidOut=0 from the next cycle, no endTransactionOut, return to IDLE.
REQ-029 beginTransactionIn outside IDLE SHALL be ignored.
REQ-030 dataValidIn in IDLE, READ, RDEND or ERROR SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE and zero the pointer, addressDataOut, dataValidOut, endTransactionOut, busyOut and busErrorOut, including mid-transaction.
REQ-032 Reset SHALL NOT clear memory contents.

Configuration
REQ-033 With macro RESPONDER_STALL_EN defined, busyOut SHALL be 1 for one cycle after every 4th accepted write beat of a burst; the master holds the beat, and reads are unaffected.
REQ-034 With RESPONDER_STALL_EN undefined, busyOut SHALL be constant 0.

Verification
REQ-035 Write 0x40000010, burst 3, BE 4'hF, data 1..4, then read 0x40000010, burst 3 -> dataValidOut at T+2..T+5 with data 1,2,3,4; endTransactionOut at T+6.
REQ-036 Write 0x40000000, BE 4'b0101, data 0xAABBCCDD over a word preloaded with 0x11223344 -> read returns 0x11BB33DD.
REQ-037 Begin at 0x40000002 or 0x400003FC with burst 1 -> busErrorOut=1 for one cycle; memory unchanged; no dataValidOut.
REQ-038 Begin at 0x50000000 -> no output activity; a following valid transaction completes normally.
REQ-039 Read burst 7 with endTransactionIn after the 3rd beat, then reset asserted during a write burst -> no endTransactionOut after the abort; all outputs 0 after the reset; earlier written words intact.
REQ-040 With RESPONDER_STALL_EN defined, 8-beat write burst -> busyOut high after beats 4 and 8; all 8 words stored correctly.
